// File: rtl/modsq_pkg.sv
// ============================================================================
// Package : modsq_pkg
// Purpose : Shared types and default parameters for the VDF modular-squaring
//           iteration sequencer and its watchdog.
// Contents: DEF_* default sizes, coeff_t, seq_state_e, status_e.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package modsq_pkg;

  localparam int DEF_MOD_LEN            = 1024;
  localparam int DEF_WORD_LEN           = 16;
  localparam int DEF_BIT_LEN            = 17;
  localparam int DEF_REDUNDANT_ELEMENTS = 2;
  localparam int DEF_NUM_ELEMENTS       = DEF_MOD_LEN / DEF_WORD_LEN + DEF_REDUNDANT_ELEMENTS;
  localparam int DEF_ITER_W             = 40;
  localparam int DEF_TIMEOUT_CYC        = 64;

  typedef logic [DEF_BIT_LEN-1:0] coeff_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ABORT   = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_e;

endpackage

`default_nettype wire

// File: rtl/modsq_watchdog.sv
// ============================================================================
// Module  : modsq_watchdog
// Purpose : Counts cycles spent waiting for a squarer result and flags when
//           the wait has run out.
// Ports   : clk, reset  - clock, synchronous active-high reset
//           clear       - restart the count at zero
//           enable      - count this cycle
//           expire      - this enabled cycle is the last one allowed
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module modsq_watchdog
  import modsq_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] count;

  // The count is expired when the increment about to happen would bring it
  // to TIMEOUT_CYC-1; with a clear in the issue cycle this ends the wait
  // exactly TIMEOUT_CYC cycles after the start pulse.
  assign expire = enable && (count == CNT_W'(TIMEOUT_CYC - 2));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/modsq_iter_sequencer.sv
// ============================================================================
// Module  : modsq_iter_sequencer
// Purpose : Squares x T times through an external modular squarer, feeding
//           the redundant coefficients back without carry resolution, and
//           returns the final coefficients with an iteration count/status.
// Ports   : clk, reset                 - clock, synchronous active-high reset
//           cmd_valid/ready, cmd_x/t   - job request (x nonredundant, T)
//           abort                      - end the running job early
//           sq_start, sq_in            - squarer launch pulse and operand
//           sq_valid, sq_out           - squarer result strobe and value
//           res_valid/ready            - result handshake
//           res_coeffs/iters/status    - result payload
//           busy, spurious             - not idle; sticky stray-result flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module modsq_iter_sequencer
  import modsq_pkg::*;
#(
  parameter int MOD_LEN            = DEF_MOD_LEN,
  parameter int WORD_LEN           = DEF_WORD_LEN,
  parameter int BIT_LEN            = DEF_BIT_LEN,
  parameter int REDUNDANT_ELEMENTS = DEF_REDUNDANT_ELEMENTS,
  parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
  parameter int ITER_W             = DEF_ITER_W,
  parameter int TIMEOUT_CYC        = DEF_TIMEOUT_CYC
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [MOD_LEN-1:0]              cmd_x,
  input  logic [ITER_W-1:0]               cmd_t,
  input  logic                            abort,
  output logic                            sq_start,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] sq_in,
  input  logic                            sq_valid,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] sq_out,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] res_coeffs,
  output logic [ITER_W-1:0]               res_iters,
  output logic [1:0]                      res_status,
  output logic                            busy,
  output logic                            spurious
);

  localparam int NONRED = MOD_LEN / WORD_LEN;
  localparam int VEC_W  = NUM_ELEMENTS * BIT_LEN;

  seq_state_e        state, state_next;
  status_e           status_q, finish_status;
  logic [ITER_W-1:0] t_reg, iter_cnt, iter_inc;
  logic [VEC_W-1:0]  x_split;
  logic              accept, take_result, finish, wd_expire;

  // Split x into WORD_LEN-bit coefficients zero-extended to BIT_LEN; the
  // redundant high coefficients start at zero.
  for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_split
    if (j < NONRED) begin : g_word
      assign x_split[j*BIT_LEN +: BIT_LEN] =
        {{(BIT_LEN-WORD_LEN){1'b0}}, cmd_x[j*WORD_LEN +: WORD_LEN]};
    end else begin : g_redundant
      assign x_split[j*BIT_LEN +: BIT_LEN] = '0;
    end
  end

  modsq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == S_ISSUE),
    .enable (state == S_WAIT),
    .expire (wd_expire)
  );

  // T never exceeds the counter range, so the equality test ends the job
  // before the increment could wrap.
  assign iter_inc = iter_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    take_result   = 1'b0;
    finish        = 1'b0;
    finish_status = ST_OK;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = (cmd_t == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_next    = S_DONE;
          finish        = 1'b1;
          finish_status = ST_ABORT;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result landing with abort is counted first; if it completes the
        // job the outcome is OK so that iters==T always implies OK.
        if (sq_valid) begin
          take_result = 1'b1;
          if (iter_inc == t_reg) begin
            state_next    = S_DONE;
            finish        = 1'b1;
            finish_status = ST_OK;
          end else if (abort) begin
            state_next    = S_DONE;
            finish        = 1'b1;
            finish_status = ST_ABORT;
          end else begin
            state_next = S_ISSUE;
          end
        end else if (abort) begin
          state_next    = S_DONE;
          finish        = 1'b1;
          finish_status = ST_ABORT;
        end else if (wd_expire) begin
          state_next    = S_DONE;
          finish        = 1'b1;
          finish_status = ST_TIMEOUT;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sq_in      <= '0;
      res_coeffs <= '0;
      t_reg      <= '0;
      iter_cnt   <= '0;
      status_q   <= ST_OK;
      spurious   <= 1'b0;
    end else begin
      if (accept) begin
        sq_in      <= x_split;
        res_coeffs <= x_split;
        t_reg      <= cmd_t;
        iter_cnt   <= '0;
        status_q   <= ST_OK;
      end
      if (take_result) begin
        sq_in      <= sq_out;
        res_coeffs <= sq_out;
        iter_cnt   <= iter_inc;
      end
      if (finish) begin
        status_q <= finish_status;
      end
      if (sq_valid && (state != S_WAIT)) begin
        spurious <= 1'b1;
      end
    end
  end

  // Suppress the launch when abort lands in the issue cycle so no result
  // comes back after the job has ended.
  assign sq_start   = (state == S_ISSUE) && !abort;
  assign cmd_ready  = (state == S_IDLE);
  assign res_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign res_iters  = iter_cnt;
  assign res_status = status_q;

endmodule

`default_nettype wire
